// File: rtl/vram_arb_pkg.sv
// Shared types for the VRAM arbiter: FSM states, requester ports and the
// default SRAM access length.
package vram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    VID  = 2'd1,
    CPU  = 2'd2,
    DMA  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    P_VID = 2'd0,
    P_CPU = 2'd1,
    P_DMA = 2'd2
  } port_e;

  localparam int ACC_CYCLES_DEF = 2;

endpackage

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one asynchronous SRAM between a video fetcher and two
// bus masters (CPU, DMA). Video has absolute priority over the masters, the
// masters alternate round-robin, and each access runs to completion.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ACC_CYCLES = ACC_CYCLES_DEF,
  parameter int ADDR_W     = 15
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce_7mn,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [7:0]        vid_dout,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_wdata,
  output logic              dma_ack,
  output logic [7:0]        dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic              mem_oe,
  output logic              vid_late
);

  localparam int CNT_W = $clog2(ACC_CYCLES + 1);

  state_e            state_q, state_d;
  port_e             last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              vid_prev_q, vid_prev_d;
  logic              vid_pend_q, vid_pend_d;
  logic              vid_late_q, vid_late_d;
  logic [7:0]        vid_dout_q, vid_dout_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic [7:0]        dma_rdata_q, dma_rdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dma_ack_q, dma_ack_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_oe_q, mem_oe_d;

  logic vid_rise;
  logic cpu_want;
  logic dma_want;
  logic acc_last;

  // Grant selection, access sequencing, completion capture and deadline flag.
  // A master whose ack is high this cycle is masked so a held request only
  // counts again from the following cycle.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    vid_prev_d   = vid_req;
    vid_dout_d   = vid_dout_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    cpu_ack_d    = 1'b0;
    dma_ack_d    = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = mem_we_q;
    mem_oe_d     = mem_oe_q;

    vid_rise   = vid_req & ~vid_prev_q;
    cpu_want   = cpu_req & ~cpu_ack_q;
    dma_want   = dma_req & ~dma_ack_q;
    acc_last   = (cnt_q == CNT_W'(ACC_CYCLES));
    vid_pend_d = vid_pend_q | vid_rise;
    vid_late_d = vid_late_q | (ce_7mn & (vid_pend_q | (state_q == VID)));

    case (state_q)
      IDLE: begin
        mem_we_d = 1'b0;
        mem_oe_d = 1'b0;
        if (vid_pend_d) begin
          state_d     = VID;
          vid_pend_d  = 1'b0;
          cnt_d       = CNT_W'(1);
          mem_addr_d  = vid_addr;
          mem_wdata_d = 8'h00;
          mem_oe_d    = 1'b1;
        end else if (cpu_want && ((last_grant_q == P_DMA) || !dma_want)) begin
          state_d      = CPU;
          last_grant_d = P_CPU;
          cnt_d        = CNT_W'(1);
          mem_addr_d   = cpu_addr;
          mem_wdata_d  = cpu_wdata;
          mem_we_d     = cpu_we;
          mem_oe_d     = ~cpu_we;
        end else if (dma_want) begin
          state_d      = DMA;
          last_grant_d = P_DMA;
          cnt_d        = CNT_W'(1);
          mem_addr_d   = dma_addr;
          mem_wdata_d  = dma_wdata;
          mem_we_d     = dma_we;
          mem_oe_d     = ~dma_we;
        end
      end
      default: begin
        if (acc_last) begin
          state_d  = IDLE;
          mem_we_d = 1'b0;
          mem_oe_d = 1'b0;
          case (state_q)
            VID: vid_dout_d = mem_rdata;
            CPU: begin
              cpu_ack_d = 1'b1;
              if (!mem_we_q) cpu_rdata_d = mem_rdata;
            end
            DMA: begin
              dma_ack_d = 1'b1;
              if (!mem_we_q) dma_rdata_d = mem_rdata;
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight and loads
  // the current vid_req level so a request held through reset is not an edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= P_DMA;
      cnt_q        <= '0;
      vid_prev_q   <= vid_req;
      vid_pend_q   <= 1'b0;
      vid_late_q   <= 1'b0;
      vid_dout_q   <= 8'h00;
      cpu_rdata_q  <= 8'h00;
      dma_rdata_q  <= 8'h00;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 8'h00;
      mem_we_q     <= 1'b0;
      mem_oe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      vid_prev_q   <= vid_prev_d;
      vid_pend_q   <= vid_pend_d;
      vid_late_q   <= vid_late_d;
      vid_dout_q   <= vid_dout_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      cpu_ack_q    <= cpu_ack_d;
      dma_ack_q    <= dma_ack_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      mem_oe_q     <= mem_oe_d;
    end
  end

  assign vid_dout  = vid_dout_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_oe    = mem_oe_q;
  assign vid_late  = vid_late_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: a behavioural SRAM behind the default-length
// instance, a table of single transactions, and hand-written sequences for
// collision, fairness, simultaneous arrival, mid-access reset and a second
// instance with long accesses for the deadline flag.
module tb_vram_arbiter;
  import vram_arb_pkg::*;

  localparam int AW = 15;

  typedef struct {
    port_e       port;
    logic        we;
    logic [AW-1:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
  } vec_t;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          ce_7mn, vid_req, cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] vid_addr, cpu_addr, dma_addr, mem_addr;
  logic [7:0]    cpu_wdata, dma_wdata, vid_dout, cpu_rdata, dma_rdata;
  logic [7:0]    mem_wdata, mem_rdata;
  logic          cpu_ack, dma_ack, mem_we, mem_oe, vid_late;

  logic          ce8, vid_req8, dma_req8;
  logic [AW-1:0] mem_addr8;
  logic [7:0]    vid_dout8, cpu_rdata8, dma_rdata8, mem_wdata8;
  logic          cpu_ack8, dma_ack8, mem_we8, mem_oe8, vid_late8;
  logic [7:0]    mem_rdata8;
  logic          zero1;
  logic [AW-1:0] zero_addr;
  logic [7:0]    zero8;

  logic [7:0] sram [0:(1<<AW)-1];
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk_sys = ~clk_sys;

  // Behavioural SRAM: write on the clock while mem_we is high, read combinational.
  always @(posedge clk_sys) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = sram[mem_addr];

  vram_arbiter #(.ACC_CYCLES(2), .ADDR_W(AW)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_7mn(ce_7mn),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_oe(mem_oe), .vid_late(vid_late)
  );

  vram_arbiter #(.ACC_CYCLES(8), .ADDR_W(AW)) dut8 (
    .clk_sys(clk_sys), .reset(reset), .ce_7mn(ce8),
    .vid_req(vid_req8), .vid_addr(zero_addr), .vid_dout(vid_dout8),
    .cpu_req(zero1), .cpu_we(zero1), .cpu_addr(zero_addr), .cpu_wdata(zero8),
    .cpu_ack(cpu_ack8), .cpu_rdata(cpu_rdata8),
    .dma_req(dma_req8), .dma_we(zero1), .dma_addr(zero_addr), .dma_wdata(zero8),
    .dma_ack(dma_ack8), .dma_rdata(dma_rdata8),
    .mem_addr(mem_addr8), .mem_wdata(mem_wdata8), .mem_rdata(mem_rdata8),
    .mem_we(mem_we8), .mem_oe(mem_oe8), .vid_late(vid_late8)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Runs one table entry from an idle arbiter and checks strobes, latency and data.
  task automatic applyStimulus(input vec_t v, input int idx);
    int n;
    logic ack;
    case (v.port)
      P_VID: begin vid_addr = v.addr; vid_req = 1'b1; end
      P_CPU: begin cpu_addr = v.addr; cpu_we = v.we; cpu_wdata = v.wdata; cpu_req = 1'b1; end
      default: begin dma_addr = v.addr; dma_we = v.we; dma_wdata = v.wdata; dma_req = 1'b1; end
    endcase
    tick();
    checkOutput($sformatf("vec%0d_addr", idx), mem_addr, v.addr);
    checkOutput($sformatf("vec%0d_we", idx), mem_we, v.we);
    checkOutput($sformatf("vec%0d_oe", idx), mem_oe, !v.we);
    if (v.port == P_VID) begin
      tick();
      tick();
      checkOutput($sformatf("vec%0d_vid_dout", idx), vid_dout, v.exp_rdata);
      checkOutput($sformatf("vec%0d_oe_off", idx), mem_oe, 1'b0);
      vid_req = 1'b0;
      tick();
    end else begin
      n = 1;
      ack = (v.port == P_CPU) ? cpu_ack : dma_ack;
      while (!ack && n < 10) begin
        tick();
        n++;
        ack = (v.port == P_CPU) ? cpu_ack : dma_ack;
      end
      checkOutput($sformatf("vec%0d_latency", idx), n, 3);
      checkOutput($sformatf("vec%0d_strobes_idle", idx), {mem_we, mem_oe}, 2'b00);
      cpu_req = 1'b0;
      dma_req = 1'b0;
      if (!v.we)
        checkOutput($sformatf("vec%0d_rdata", idx),
                    (v.port == P_CPU) ? cpu_rdata : dma_rdata, v.exp_rdata);
      tick();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t vecs[9];
    int n, t0, acks_seen, last_ack_cyc;
    logic [1:0] prev_ack;
    string order;

    for (int i = 0; i < (1 << AW); i++) sram[i] = 8'h00;
    sram[15'h1A00] = 8'h5C;

    vecs[0] = '{P_CPU, 1'b1, 15'h0010, 8'h11, 8'h00};
    vecs[1] = '{P_DMA, 1'b1, 15'h0020, 8'h22, 8'h00};
    vecs[2] = '{P_CPU, 1'b0, 15'h0020, 8'h00, 8'h22};
    vecs[3] = '{P_DMA, 1'b0, 15'h0010, 8'h00, 8'h11};
    vecs[4] = '{P_DMA, 1'b1, 15'h7FFF, 8'hF0, 8'h00};
    vecs[5] = '{P_CPU, 1'b0, 15'h7FFF, 8'h00, 8'hF0};
    vecs[6] = '{P_VID, 1'b0, 15'h0010, 8'h00, 8'h11};
    vecs[7] = '{P_CPU, 1'b0, 15'h0000, 8'h00, 8'h00};
    vecs[8] = '{P_VID, 1'b0, 15'h7FFF, 8'h00, 8'hF0};

    ce_7mn = 0; vid_req = 1; vid_addr = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    ce8 = 0; vid_req8 = 0; dma_req8 = 0; mem_rdata8 = 8'h00;
    zero1 = 0; zero_addr = '0; zero8 = '0;

    // Reset values, with vid_req held high through reset.
    reset = 1'b1;
    tick();
    tick();
    checkOutput("rst_mem_we", mem_we, 1'b0);
    checkOutput("rst_mem_oe", mem_oe, 1'b0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_vid_dout", vid_dout, 0);
    checkOutput("rst_acks", {cpu_ack, dma_ack}, 2'b00);
    checkOutput("rst_rdata", {cpu_rdata, dma_rdata}, 16'h0000);
    checkOutput("rst_vid_late", vid_late, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("held_vid_req_no_edge", mem_oe, 1'b0);
    end
    vid_req = 1'b0;
    tick();
    tick();

    // Scenario 1: video read on a ce_7mn tick.
    vid_addr = 15'h1A00; vid_req = 1'b1; ce_7mn = 1'b1;
    tick();
    ce_7mn = 1'b0;
    checkOutput("s1_oe_t1", mem_oe, 1'b1);
    checkOutput("s1_addr_t1", mem_addr, 15'h1A00);
    checkOutput("s1_dout_hold_t1", vid_dout, 8'h00);
    tick();
    checkOutput("s1_oe_t2", mem_oe, 1'b1);
    checkOutput("s1_dout_hold_t2", vid_dout, 8'h00);
    tick();
    checkOutput("s1_oe_t3", mem_oe, 1'b0);
    checkOutput("s1_vid_dout", vid_dout, 8'h5C);
    checkOutput("s1_vid_late", vid_late, 1'b0);
    vid_req = 1'b0;
    tick();

    // Table-driven single transactions.
    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);

    // Scenario 2: CPU write, then a video read of the same address next cycle.
    cpu_addr = 15'h4000; cpu_wdata = 8'hAA; cpu_we = 1'b1; cpu_req = 1'b1;
    t0 = cyc;
    tick();
    vid_addr = 15'h4000; vid_req = 1'b1;
    n = 0;
    while (!cpu_ack && n < 10) begin tick(); n++; end
    checkOutput("s2_cpu_ack_cycle", cyc - t0, 3);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    checkOutput("s2_vid_granted_oe", mem_oe, 1'b1);
    checkOutput("s2_vid_granted_addr", mem_addr, 15'h4000);
    tick();
    tick();
    checkOutput("s2_vid_done_within_6", (cyc - (t0 + 1)) <= 6, 1'b1);
    checkOutput("s2_vid_dout_ordered", vid_dout, 8'hAA);
    vid_req = 1'b0;
    tick();

    // Scenario 3: fairness with both masters held.
    do_reset();
    tick();
    cpu_addr = 15'h0010; cpu_we = 1'b0; cpu_req = 1'b1;
    dma_addr = 15'h0020; dma_we = 1'b0; dma_req = 1'b1;
    order = "";
    acks_seen = 0;
    prev_ack = 2'b00;
    n = 0;
    while (acks_seen < 4 && n < 40) begin
      tick();
      n++;
      checkOutput("s3_no_double_ack", cpu_ack & dma_ack, 1'b0);
      checkOutput("s3_ack_single_pulse", |(prev_ack & {cpu_ack, dma_ack}), 1'b0);
      prev_ack = {cpu_ack, dma_ack};
      if (cpu_ack) begin order = {order, "C"}; acks_seen++; end
      if (dma_ack) begin order = {order, "D"}; acks_seen++; end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    n_cmp++;
    if (order != "CDCD") begin
      n_fail++;
      $display("[TB] FAIL s3_grant_order: got %s expected CDCD", order);
    end
    tick();
    checkOutput("s3_acks_drop", {cpu_ack, dma_ack}, 2'b00);
    tick();
    tick();

    // Scenario 4: video edge and CPU request in the same idle cycle.
    vid_addr = 15'h7FFF; vid_req = 1'b1;
    cpu_addr = 15'h0010; cpu_we = 1'b0; cpu_req = 1'b1;
    t0 = cyc;
    tick();
    checkOutput("s4_vid_first_addr", mem_addr, 15'h7FFF);
    tick();
    tick();
    checkOutput("s4_vid_dout", vid_dout, 8'hF0);
    last_ack_cyc = cyc;
    n = 0;
    while (!cpu_ack && n < 10) begin tick(); n++; end
    checkOutput("s4_cpu_after_vid", cyc - last_ack_cyc, 3);
    checkOutput("s4_cpu_rdata", cpu_rdata, 8'h11);
    cpu_req = 1'b0; vid_req = 1'b0;
    tick();

    // Scenario 5: reset during the second cycle of a DMA write.
    dma_addr = 15'h0100; dma_wdata = 8'h5A; dma_we = 1'b1; dma_req = 1'b1;
    tick();
    checkOutput("s5_we_c1", mem_we, 1'b1);
    tick();
    checkOutput("s5_we_c2", mem_we, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0; dma_req = 1'b0; dma_we = 1'b0;
    checkOutput("s5_we_aborted", mem_we, 1'b0);
    checkOutput("s5_no_dma_ack", dma_ack, 1'b0);
    checkOutput("s5_idle_addr", mem_addr, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("s5_no_late_ack", dma_ack, 1'b0);
    end

    // Scenario 6: long accesses with continuous DMA; video misses its deadline.
    dma_req8 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      ce8 = (i % 8 == 0);
      if (i == 16) vid_req8 = 1'b1;
      if (i == 60) begin vid_req8 = 1'b0; dma_req8 = 1'b0; end
      if (i == 15) checkOutput("s6_late_before_vid", vid_late8, 1'b0);
      if (i == 50) checkOutput("s6_late_set", vid_late8, 1'b1);
      tick();
    end
    ce8 = 1'b0;
    checkOutput("s6_late_sticky", vid_late8, 1'b1);
    checkOutput("s6_main_late_clear", vid_late, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ACC_CYCLES, default 2: clk_sys cycles each SRAM access holds address, data and strobes.
REQ-002 SHALL have parameter ADDR_W, default 15: VRAM address width.
REQ-003 clk_sys  in  1  system clock; all logic posedge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 ce_7mn  in  1  video-timing tick; one clk_sys cycle wide.
REQ-006 vid_req  in  1  video fetch request level; rises on one ce_7mn, falls on a later one.
REQ-007 vid_addr  in  ADDR_W  video fetch address; stable while vid_req=1.
REQ-008 vid_dout  out  8  last completed video read data.
REQ-009 cpu_req, cpu_we  in  1 each  CPU request level and write qualifier.
REQ-010 cpu_addr  in  ADDR_W; cpu_wdata  in  8  CPU address and write data.
REQ-011 cpu_ack  out  1  one-cycle pulse on CPU access completion; cpu_rdata  out  8  read data, valid with cpu_ack.
REQ-012 dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata: same widths and semantics as the CPU port.
REQ-013 mem_addr  out  ADDR_W; mem_wdata  out  8; mem_rdata  in  8; mem_we  out  1; mem_oe  out  1  SRAM port.
REQ-014 vid_late  out  1  sticky flag: a video fetch missed its deadline.

Function
REQ-015 FSM states SHALL be IDLE, VID, CPU, DMA.
REQ-016 A rising edge of vid_req SHALL set vid_pend; vid_pend clears when the VID access starts.
REQ-017 From IDLE, priority SHALL be vid_pend, then CPU/DMA by round-robin. last_grant toggles on each CPU or DMA grant. CPU wins when last_grant=DMA or DMA is idle.
REQ-018 A grant in cycle t SHALL drive mem_addr/mem_wdata/mem_we/mem_oe from t+1 through t+ACC_CYCLES.
REQ-019 mem_rdata SHALL be captured on the final access cycle.
REQ-020 The FSM SHALL return to IDLE at t+ACC_CYCLES+1.
REQ-021 Completion SHALL update vid_dout (VID), or pulse cpu_ack/dma_ack with rdata (CPU/DMA), at t+ACC_CYCLES+1.
REQ-022 Accesses SHALL NOT be pre-empted. A video request arriving mid-access waits at most ACC_CYCLES+1 cycles.
REQ-023 mem_we SHALL be asserted only during CPU/DMA writes. mem_oe SHALL be asserted only during reads. Both SHALL be 0 in IDLE.
REQ-024 A requester SHALL hold req until its ack. The arbiter SHALL NOT re-grant a port in the cycle its ack is high.
REQ-025 Each port SHALL track acked-but-still-high requests. If req is still high in the cycle after ack, it SHALL count as a new request.
REQ-026 If ce_7mn occurs while vid_pend=1 or state=VID, vid_late SHALL be set. Only reset clears it.
REQ-027 Simultaneous vid_req rise and CPU/DMA request in IDLE: video SHALL be granted first.
REQ-028 A CPU write and a video read to the same address SHALL complete in grant order, with no merging.
REQ-029 vid_dout SHALL hold its value when no video access completes.

Reset
REQ-030 On reset, the following SHALL clear within the same cycle: state=IDLE, vid_pend=0, last_grant=DMA, vid_late=0, vid_dout=0, cpu_rdata=0, dma_rdata=0, cpu_ack=0, dma_ack=0, mem_we=0, mem_oe=0, mem_addr=0.
REQ-031 Reset mid-access SHALL abort the access: mem_we=0 next cycle and no ack issued.
REQ-032 A vid_req already high at reset release SHALL NOT count as a rising edge.

Structure
REQ-033 A shared package vram_arb_pkg SHALL hold the state enum, port-index enum (VID/CPU/DMA) and the ACC_CYCLES default.
REQ-034 No sub-module is needed: FSM, access counter and edge detect live in vram_arbiter.
REQ-035 The access counter SHALL be $clog2(ACC_CYCLES+1) bits wide.

Verification
REQ-036 Scenario 1, video read: vid_req rises with vid_addr=0x1A00 and mem_rdata=0x5C. Required: mem_oe on cycles t+1..t+2, vid_dout=0x5C at t+3, vid_late=0.
REQ-037 Scenario 2, video collides with write: CPU write 0x4000<-0xAA is granted, then vid_req rises next cycle. Required: video granted in IDLE right after cpu_ack, and video completes within 6 cycles.
REQ-038 Scenario 3, fairness: cpu_req and dma_req both held for 4 accesses. Required: grants alternate CPU, DMA, CPU, DMA starting with CPU, each ack a single-cycle pulse.
REQ-039 Scenario 4, simultaneous arrival: vid_req rise and cpu_req in the same IDLE cycle. Required: VID granted first, CPU acked 3 cycles later than VID completion.
REQ-040 Scenario 5, mid-access reset: reset asserted during the 2nd cycle of a DMA write. Required: mem_we=0 next cycle, no dma_ack, state IDLE.
REQ-041 Scenario 6, deadline miss: continuous DMA traffic, ACC_CYCLES=8, ce_7mn every 8 cycles. Required: vid_late=1 and it stays set.
